// File: rtl/utopia_rx_arbiter.sv
// utopia_rx_arbiter: round-robin scheduler sharing the cell-forwarding engine
// among NumRx UTOPIA receive ports. One port is granted at a time; the grant
// is held until the engine reports cell_done, then priority rotates past it.
// Per-port saturating grant counters are readable through cnt_sel/cnt_out.
// Optional watchdog: define RX_ARB_TIMEOUT_EN to abort a grant that sees no
// cell_done within TIMEOUT cycles (timeout_err pulses for one cycle).
//
// state | meaning
// IDLE  | no grant outstanding, picking a winner from req & port_en
// BUSY  | grant held for one port until cell_done (or watchdog expiry)
module utopia_rx_arbiter #(
   parameter int NumRx   = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NumRx-1:0]                      req,
   input  logic [NumRx-1:0]                      port_en,
   input  logic                                  cell_done,
   output logic [NumRx-1:0]                      grant,
   output logic                                  grant_valid,
   output logic [((NumRx>1)?$clog2(NumRx):1)-1:0] grant_id,
   input  logic [((NumRx>1)?$clog2(NumRx):1)-1:0] cnt_sel,
   output logic [CNT_W-1:0]                      cnt_out,
   output logic                                  timeout_err
);

   localparam int IdW = (NumRx > 1) ? $clog2(NumRx) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state;
   logic [IdW-1:0]       ptr;
   logic [CNT_W-1:0]     cnt [NumRx];
   logic [NumRx-1:0]     elig;
   logic                 win_found;
   logic [IdW-1:0]       win_id;
   logic [NumRx-1:0]     grant_nxt;
   logic [IdW-1:0]       ptr_after;

`ifdef RX_ARB_TIMEOUT_EN
   localparam int WdW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
   logic [WdW-1:0]       wd;
   logic                 tmo;
   assign timeout_err = tmo;
`else
   assign timeout_err = 1'b0;
`endif

   assign elig        = req & port_en;
   assign grant_valid = |grant;
   assign ptr_after   = IdW'((int'(grant_id) + 1) % NumRx);

   // Winner search: scan downward so the last hit is the first set bit from ptr
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_id    = '0;
      grant_nxt = '0;
      for (int i = NumRx - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NumRx;
         if (elig[idx]) begin
            win_found = 1'b1;
            win_id    = IdW'(idx);
         end
      end
      if (win_found) grant_nxt[win_id] = 1'b1;
   end

   // Counter readback mux; out-of-range selects read as zero
   always_comb begin
      cnt_out = '0;
      if (int'(cnt_sel) < NumRx) cnt_out = cnt[cnt_sel];
   end

   // Grant FSM with rotation pointer, grant counters and optional watchdog
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         grant_id <= '0;
         ptr      <= '0;
         for (int i = 0; i < NumRx; i++) cnt[i] <= '0;
`ifdef RX_ARB_TIMEOUT_EN
         wd       <= '0;
         tmo      <= 1'b0;
`endif
      end else begin
`ifdef RX_ARB_TIMEOUT_EN
         tmo <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (win_found) begin
                  grant    <= grant_nxt;
                  grant_id <= win_id;
                  state    <= BUSY;
                  if (cnt[win_id] != {CNT_W{1'b1}}) cnt[win_id] <= cnt[win_id] + 1'b1;
`ifdef RX_ARB_TIMEOUT_EN
                  wd       <= '0;
`endif
               end
            end
            BUSY: begin
               // cell_done takes precedence over a watchdog expiry on the same cycle
               if (cell_done) begin
                  grant    <= '0;
                  grant_id <= '0;
                  ptr      <= ptr_after;
                  state    <= IDLE;
               end
`ifdef RX_ARB_TIMEOUT_EN
               else if (wd == WdW'(TIMEOUT - 1)) begin
                  grant    <= '0;
                  grant_id <= '0;
                  ptr      <= ptr_after;
                  state    <= IDLE;
                  tmo      <= 1'b1;
               end else begin
                  wd <= wd + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_utopia_rx_arbiter.sv
// Directed bench for utopia_rx_arbiter: reset, rotation, masking, lone
// requester, stray cell_done, counter saturation and (if enabled) watchdog.
// Counters are built 4 bits wide so saturation is reachable in a short run.
module tb_utopia_rx_arbiter;

   localparam int N  = 4;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req;
   logic [N-1:0]  port_en;
   logic          cell_done;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [1:0]    grant_id;
   logic [1:0]    cnt_sel;
   logic [CW-1:0] cnt_out;
   logic          timeout_err;

   int checks   = 0;
   int failures = 0;

   utopia_rx_arbiter #(.NumRx(N), .CNT_W(CW), .TIMEOUT(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .port_en     (port_en),
      .cell_done   (cell_done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .cnt_sel     (cnt_sel),
      .cnt_out     (cnt_out),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input logic [1:0] port, input logic [31:0] exp);
      cnt_sel = port;
      #1;
      chk("cnt_out", 32'(cnt_out), exp);
   endtask

   task automatic chk_grant(input string tag, input int id);
      chk({tag, "_grant"}, 32'(grant), 32'(1) << id);
      chk({tag, "_id"}, 32'(grant_id), 32'(id));
      chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant0"}, 32'(grant), 32'd0);
      chk({tag, "_valid0"}, 32'(grant_valid), 32'd0);
      chk({tag, "_id0"}, 32'(grant_id), 32'd0);
   endtask

   // One full grant of port id: grant appears, held for hold cycles, cell_done, dead cycle
   task automatic do_grant(input string tag, input int id, input int hold);
      cyc();
      chk_grant(tag, id);
      repeat (hold) cyc();
      chk({tag, "_held"}, 32'(grant), 32'(1) << id);
      cell_done = 1'b1;
      cyc();
      cell_done = 1'b0;
      chk_idle({tag, "_dead"});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; port_en = 4'b1111; cell_done = 1'b0; cnt_sel = '0;
      cyc(); cyc();
      chk_idle("reset");
      chk("reset_tmo", 32'(timeout_err), 32'd0);
      for (int p = 0; p < N; p++) chk_cnt(2'(p), 32'd0);
      rst = 1'b0;

      // 1: reset mid-transfer on port 2
      req = 4'b0100;
      cyc();
      chk_grant("t1", 2);
      cyc();
      rst = 1'b1;
      #1;
      chk_idle("t1_async");
      chk_cnt(2'd2, 32'd0);
      rst = 1'b0;
      cyc();
      chk_grant("t1_after", 2);
      chk_cnt(2'd2, 32'd1);
      cell_done = 1'b1;
      cyc();
      cell_done = 1'b0;
      req = '0;
      cyc();

      // 2: full rotation
      do_reset();
      req = 4'b1111; port_en = 4'b1111;
      do_grant("t2_a", 0, 2);
      do_grant("t2_b", 1, 2);
      do_grant("t2_c", 2, 2);
      do_grant("t2_d", 3, 2);
      do_grant("t2_e", 0, 2);
      chk_cnt(2'd0, 32'd2);
      chk_cnt(2'd1, 32'd1);
      chk_cnt(2'd2, 32'd1);
      chk_cnt(2'd3, 32'd1);

      // 3: masking, port_en change during a grant
      req = '0;
      do_reset();
      req = 4'b1111; port_en = 4'b1011;
      do_grant("t3_a", 0, 1);
      cyc();
      chk_grant("t3_b", 1);
      port_en = 4'b1001;
      cyc(); cyc();
      chk("t3_b_hold", 32'(grant), 32'h2);
      cell_done = 1'b1;
      cyc();
      cell_done = 1'b0;
      chk_idle("t3_b_dead");
      do_grant("t3_c", 3, 1);
      do_grant("t3_d", 0, 1);
      chk_cnt(2'd2, 32'd0);
      chk_cnt(2'd0, 32'd2);

      // 4: lone requester re-wins with one dead cycle
      req = 4'b1000; port_en = 4'b1111;
      do_grant("t4_a", 3, 0);
      do_grant("t4_b", 3, 0);
      do_grant("t4_c", 3, 0);
      chk_cnt(2'd3, 32'd4);

      // 5: stray cell_done, req drop while busy, saturation
      req = '0;
      cell_done = 1'b1;
      cyc(); cyc();
      cell_done = 1'b0;
      chk_idle("t5_stray");
      chk_cnt(2'd3, 32'd4);
      chk_cnt(2'd0, 32'd2);
      req = 4'b0101;
      cyc();
      chk_grant("t5_ptr", 0);
      req = '0;
      cyc(); cyc();
      chk("t5_drop_hold", 32'(grant), 32'h1);
      cell_done = 1'b1;
      cyc();
      cell_done = 1'b0;
      chk_idle("t5_drop_dead");
      chk_cnt(2'd0, 32'd3);
      req = 4'b1000;
      for (int k = 0; k < 11; k++) do_grant("t5_sat", 3, 0);
      chk_cnt(2'd3, 32'd15);
      do_grant("t5_sat_more", 3, 0);
      chk_cnt(2'd3, 32'd15);
      req = '0;
      cyc();

`ifdef RX_ARB_TIMEOUT_EN
      // 6: watchdog abort
      do_reset();
      req = 4'b0110;
      cyc();
      chk_grant("t6", 1);
      repeat (63) cyc();
      chk("t6_still", 32'(grant), 32'h2);
      chk("t6_tmo_lo", 32'(timeout_err), 32'd0);
      cyc();
      chk_idle("t6_abort");
      chk("t6_tmo_hi", 32'(timeout_err), 32'd1);
      cyc();
      chk_grant("t6_next", 2);
      chk("t6_tmo_end", 32'(timeout_err), 32'd0);
`else
      chk("t6_tmo_tied", 32'(timeout_err), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
